// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: request inputs and status outputs of the reset sequencer
interface reset_sequencer_if #(
    parameter int NUM_DOM = 3
);
    logic               sw_rst_req;
    logic               wdog_en;
    logic               wdog_kick;
    logic [NUM_DOM-1:0] dom_rst_n;
    logic               sys_ready;
    logic [1:0]         rst_cause;
    logic               wdog_fired;

    modport master (
        output sw_rst_req, wdog_en, wdog_kick,
        input  dom_rst_n, sys_ready, rst_cause, wdog_fired
    );

    modport slave (
        input  sw_rst_req, wdog_en, wdog_kick,
        output dom_rst_n, sys_ready, rst_cause, wdog_fired
    );
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer: ordered release of reset domains with hold, gap, software reset and watchdog
module reset_sequencer #(
    parameter int NUM_DOM  = 3,
    parameter int HOLD_CYC = 16,
    parameter int GAP_CYC  = 4,
    parameter int WDOG_CYC = 1000000
) (
    input  logic clk,
    input  logic rst,
    reset_sequencer_if.slave bus
);
    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam int WW = $clog2(WDOG_CYC);

    localparam logic [1:0] S_HOLD    = 2'd0;
    localparam logic [1:0] S_RELEASE = 2'd1;
    localparam logic [1:0] S_RUN     = 2'd2;

    logic [1:0]         state;
    logic [HW-1:0]      hold_cnt;
    logic [GW-1:0]      gap_cnt;
    logic [WW-1:0]      wdog_cnt;
    logic [NUM_DOM-1:0] dom_q;
    logic               ready_q;
    logic [1:0]         cause_q;
    logic               fired_q;
    logic               timeout;
    logic               rst_evt;

    assign timeout = (state == S_RUN) && bus.wdog_en && !bus.wdog_kick && (wdog_cnt == WW'(WDOG_CYC - 1));
    assign rst_evt = timeout || bus.sw_rst_req;

    assign bus.dom_rst_n  = dom_q;
    assign bus.sys_ready  = ready_q;
    assign bus.rst_cause  = cause_q;
    assign bus.wdog_fired = fired_q;

    // Sequencer FSM: hold, release domains one by one as a thermometer code, then run
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_HOLD;
            hold_cnt <= '0;
            gap_cnt  <= '0;
            dom_q    <= '0;
            ready_q  <= 1'b0;
            cause_q  <= 2'b00;
            fired_q  <= 1'b0;
        end else if (rst_evt) begin
            state    <= S_HOLD;
            hold_cnt <= '0;
            gap_cnt  <= '0;
            dom_q    <= '0;
            ready_q  <= 1'b0;
            cause_q  <= timeout ? 2'b10 : 2'b01;
            if (timeout) fired_q <= 1'b1;
        end else begin
            case (state)
                S_HOLD: begin
                    if (hold_cnt == HW'(HOLD_CYC - 1)) begin
                        state   <= S_RELEASE;
                        gap_cnt <= '0;
                        dom_q   <= NUM_DOM'(1);
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (gap_cnt == GW'(GAP_CYC - 1)) begin
                        gap_cnt <= '0;
                        if (&dom_q) begin
                            state   <= S_RUN;
                            ready_q <= 1'b1;
                        end else begin
                            dom_q <= NUM_DOM'({dom_q, 1'b1});
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                S_RUN: ;
                default: state <= S_HOLD;
            endcase
        end
    end

    // Watchdog counter: runs only in RUN while enabled, cleared on kick, saturates at its terminal value
    always_ff @(posedge clk) begin
        if (rst || rst_evt || state != S_RUN || !bus.wdog_en || bus.wdog_kick)
            wdog_cnt <= '0;
        else if (wdog_cnt != WW'(WDOG_CYC - 1))
            wdog_cnt <= wdog_cnt + 1'b1;
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed scoreboard bench for the reset sequencer
module tb_reset_sequencer;
    logic clk = 1'b0;
    logic rst;

    typedef struct {
        string      tag;
        logic [2:0] dom;
        logic       rdy;
        logic [1:0] cause;
        logic       fired;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    reset_sequencer_if #(.NUM_DOM(3)) bus ();

    reset_sequencer #(
        .NUM_DOM(3), .HOLD_CYC(16), .GAP_CYC(4), .WDOG_CYC(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp(input string tag, input logic [2:0] dom, input logic rdy,
                       input logic [1:0] cause, input logic fired);
        exp_t x;
        x.tag = tag; x.dom = dom; x.rdy = rdy; x.cause = cause; x.fired = fired;
        q.push_back(x);
    endtask

    task automatic chk();
        exp_t x;
        logic [6:0] obs, want;
        x = q.pop_front();
        obs  = {bus.dom_rst_n, bus.sys_ready, bus.rst_cause, bus.wdog_fired};
        want = {x.dom, x.rdy, x.cause, x.fired};
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed dom/rdy/cause/fired=%b expected %b at %0t", x.tag, obs, want, $time);
        end
    endtask

    // Checks n edges of a release sequence counted from the reset-event edge (edge 0)
    task automatic seq(input string tag, input int n, input logic [1:0] cause, input logic fired);
        for (int e = 1; e <= n; e++) begin
            exp(tag, {e >= 24, e >= 20, e >= 16}, e >= 28, cause, fired);
            cyc(1);
            chk();
        end
    endtask

    task automatic run_hold(input string tag, input int n, input logic [1:0] cause, input logic fired);
        for (int i = 0; i < n; i++) begin
            exp(tag, 3'b111, 1'b1, cause, fired);
            cyc(1);
            chk();
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.sw_rst_req = 1'b0;
        bus.wdog_en    = 1'b0;
        bus.wdog_kick  = 1'b0;

        exp("t1_reset", 3'b000, 1'b0, 2'b00, 1'b0);
        cyc(3);
        chk();
        rst = 1'b0;
        seq("t1_seq", 28, 2'b00, 1'b0);

        bus.sw_rst_req = 1'b1;
        exp("t2_swrst", 3'b000, 1'b0, 2'b01, 1'b0);
        cyc(1);
        bus.sw_rst_req = 1'b0;
        chk();
        seq("t2_seq", 28, 2'b01, 1'b0);

        bus.sw_rst_req = 1'b1;
        exp("t3_swrst", 3'b000, 1'b0, 2'b01, 1'b0);
        cyc(1);
        bus.sw_rst_req = 1'b0;
        chk();
        seq("t3_partial", 21, 2'b01, 1'b0);
        bus.sw_rst_req = 1'b1;
        exp("t3_abort", 3'b000, 1'b0, 2'b01, 1'b0);
        cyc(1);
        bus.sw_rst_req = 1'b0;
        chk();
        seq("t3_restart", 28, 2'b01, 1'b0);

        bus.wdog_en = 1'b1;
        run_hold("t4_before_fire", 63, 2'b01, 1'b0);
        exp("t4_fire", 3'b000, 1'b0, 2'b10, 1'b1);
        cyc(1);
        chk();
        seq("t4_seq", 28, 2'b10, 1'b1);
        for (int k = 0; k < 4; k++) begin
            run_hold("t4_kicked", 49, 2'b10, 1'b1);
            bus.wdog_kick = 1'b1;
            exp("t4_kick", 3'b111, 1'b1, 2'b10, 1'b1);
            cyc(1);
            bus.wdog_kick = 1'b0;
            chk();
        end

        run_hold("t5_pre_timeout", 63, 2'b10, 1'b1);
        bus.wdog_kick = 1'b1;
        exp("t5_kick_wins", 3'b111, 1'b1, 2'b10, 1'b1);
        cyc(1);
        bus.wdog_kick = 1'b0;
        chk();
        bus.wdog_en = 1'b0;
        exp("t5_disabled", 3'b111, 1'b1, 2'b10, 1'b1);
        cyc(200);
        chk();
        bus.wdog_en = 1'b1;
        run_hold("t5_reenabled", 63, 2'b10, 1'b1);
        bus.sw_rst_req = 1'b1;
        exp("t5_coincident", 3'b000, 1'b0, 2'b10, 1'b1);
        cyc(1);
        bus.sw_rst_req = 1'b0;
        chk();

        bus.wdog_en = 1'b0;
        seq("t6_partial", 21, 2'b10, 1'b1);
        rst = 1'b1;
        exp("t6_rst", 3'b000, 1'b0, 2'b00, 1'b0);
        cyc(1);
        chk();
        exp("t6_rst_held", 3'b000, 1'b0, 2'b00, 1'b0);
        cyc(2);
        chk();
        rst = 1'b0;
        seq("t6_seq", 28, 2'b00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
